// File: rtl/pair_sym_pkg.sv
// Shared definitions for the pair-symbol link: line symbol encodings and the
// transmitter state encoding, reused by the receiver/checker side.
package pair_sym_pkg;

    localparam logic [1:0] SYM_IDLE = 2'b01;
    localparam logic [1:0] SYM_ZERO = 2'b01;
    localparam logic [1:0] SYM_ONE  = 2'b10;
    localparam logic [1:0] SYM_MARK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MARK = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } state_e;

    // Manchester symbol for one payload bit; never has equal bits.
    function automatic logic [1:0] data_sym(input logic b);
        return b ? SYM_ONE : SYM_ZERO;
    endfunction

endpackage

// File: rtl/pair_sym_tx.sv
// Framed 2-bit symbol transmitter: marker, DATA_W Manchester data symbols
// (MSB first) and an optional even-parity symbol, one symbol per clock.
module pair_sym_tx #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic [1:0]        sym_out,
    output logic              busy,
    output logic              frame_done
);
    import pair_sym_pkg::*;

    localparam int unsigned         CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                par_q,   par_d;
    logic [1:0]          sym_q,   sym_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                last_sym;
    logic                accept;

    // Last symbol of a frame is on the line; a new word may be taken now.
    always_comb begin
        last_sym = (state_q == ST_PAR) ||
                   ((state_q == ST_DATA) && (cnt_q == CNT_LAST) && !PARITY_EN);
        tx_ready = (state_q == ST_IDLE) || last_sym;
        accept   = tx_valid && tx_ready;
    end

    // Next-state, shift register, bit counter and parity capture.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_MARK;
                    shreg_d = tx_data;
                    par_d   = ^tx_data;
                end
            end
            ST_MARK: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (PARITY_EN) begin
                        state_d = ST_PAR;
                    end else if (accept) begin
                        state_d = ST_MARK;
                        shreg_d = tx_data;
                        par_d   = ^tx_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PAR: begin
                if (accept) begin
                    state_d = ST_MARK;
                    shreg_d = tx_data;
                    par_d   = ^tx_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next register values so that sym_out,
    // busy and frame_done are flops that line up with the registered state.
    always_comb begin
        case (state_d)
            ST_MARK: sym_d = SYM_MARK;
            ST_DATA: sym_d = data_sym(shreg_d[DATA_W-1]);
            ST_PAR:  sym_d = data_sym(par_d);
            default: sym_d = SYM_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_PAR) ||
                 ((state_d == ST_DATA) && (cnt_d == CNT_LAST) && !PARITY_EN);
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            sym_q   <= SYM_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            sym_q   <= sym_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sym_out    = sym_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pair_sym_tx.sv
// Directed bench for pair_sym_tx: one instance with parity, one without,
// both fed from the same handshake inputs.
module tb_pair_sym_tx;

    logic       clk;
    logic       rstn;
    logic       tx_valid;
    logic [7:0] tx_data;

    logic       rdy1, busy1, fd1;
    logic [1:0] sym1;
    logic       rdy0, busy0, fd0;
    logic [1:0] sym0;

    int total;
    int bad;

    pair_sym_tx #(.DATA_W(8), .PARITY_EN(1'b1)) dut_p1 (
        .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .tx_ready(rdy1),
        .tx_data(tx_data), .sym_out(sym1), .busy(busy1), .frame_done(fd1)
    );

    pair_sym_tx #(.DATA_W(8), .PARITY_EN(1'b0)) dut_p0 (
        .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .tx_ready(rdy0),
        .tx_data(tx_data), .sym_out(sym0), .busy(busy0), .frame_done(fd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream equal-bit detector on the parity instance.
    logic det_q;
    int   det_cnt;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) det_q <= 1'b0;
        else       det_q <= (sym1[1] == sym1[0]);
    end
    initial det_cnt = 0;
    always @(posedge clk) if (det_q) det_cnt = det_cnt + 1;

    typedef struct packed {
        logic            pen;
        logic [7:0]      data;
        logic [9:0][1:0] syms;   // syms[9] is the first symbol
        int              len;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] sym_of(input logic pen);
        return pen ? sym1 : sym0;
    endfunction
    function automatic logic busy_of(input logic pen);
        return pen ? busy1 : busy0;
    endfunction
    function automatic logic fd_of(input logic pen);
        return pen ? fd1 : fd0;
    endfunction
    function automatic logic rdy_of(input logic pen);
        return pen ? rdy1 : rdy0;
    endfunction

    // One frame from idle; called just after a clock edge with both DUTs idle.
    task automatic run_frame(input logic pen, input logic [7:0] d,
                             input logic [9:0][1:0] syms, input int len);
        tx_valid = 1'b1;
        tx_data  = d;
        chk("ready_idle", 32'(rdy_of(pen)), 32'd1);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            tx_valid = 1'b0;
            tx_data  = ~d;
            chk("sym", 32'(sym_of(pen)), 32'(syms[9-i]));
            chk("busy", 32'(busy_of(pen)), 32'd1);
            chk("frame_done", 32'(fd_of(pen)), 32'(i == len - 1));
        end
        @(posedge clk); #1;
        chk("sym_after", 32'(sym_of(pen)), 32'h1);
        chk("busy_after", 32'(busy_of(pen)), 32'd0);
        chk("fd_after", 32'(fd_of(pen)), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [1:0] b2b_sym [21];
    int         det_start;
    int         fd_seen;

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{pen: 1'b1, data: 8'hA5, len: 10, syms:
            {2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01}};
        vecs[1] = '{pen: 1'b1, data: 8'h3C, len: 10, syms:
            {2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01}};
        vecs[2] = '{pen: 1'b1, data: 8'h01, len: 10, syms:
            {2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10}};
        vecs[3] = '{pen: 1'b1, data: 8'hFE, len: 10, syms:
            {2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10}};
        vecs[4] = '{pen: 1'b0, data: 8'h80, len: 9, syms:
            {2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01}};
        vecs[5] = '{pen: 1'b0, data: 8'h7F, len: 9, syms:
            {2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01}};

        // Reset
        rstn     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #12;
        chk("rst_sym", 32'(sym1), 32'h1);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_fd", 32'(fd1), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_sym1", 32'(sym1), 32'h1);
        chk("post_rst_busy1", 32'(busy1), 32'd0);
        chk("post_rst_rdy1", 32'(rdy1), 32'd1);
        chk("post_rst_fd1", 32'(fd1), 32'd0);
        chk("post_rst_sym0", 32'(sym0), 32'h1);
        chk("post_rst_rdy0", 32'(rdy0), 32'd1);

        // Table of single frames; the first three also feed the detector count
        det_start = det_cnt;
        for (int v = 0; v < 3; v++)
            run_frame(vecs[v].pen, vecs[v].data, vecs[v].syms, vecs[v].len);
        chk("detector_pulses", 32'(det_cnt - det_start), 32'd3);
        for (int v = 3; v < 6; v++)
            run_frame(vecs[v].pen, vecs[v].data, vecs[v].syms, vecs[v].len);

        // Back-to-back FF then 00 on the parity instance; parity of both is 0
        b2b_sym[0] = 2'b11;
        for (int i = 1; i <= 8; i++) b2b_sym[i] = 2'b10;
        b2b_sym[9]  = 2'b01;
        b2b_sym[10] = 2'b11;
        for (int i = 11; i <= 19; i++) b2b_sym[i] = 2'b01;
        b2b_sym[20] = 2'b01;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        for (int i = 0; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 0)  tx_data  = 8'h00;
            if (i == 10) tx_valid = 1'b0;
            chk("b2b_sym", 32'(sym1), 32'(b2b_sym[i]));
            chk("b2b_ready", 32'(rdy1), 32'((i == 9) || (i == 19) || (i == 20)));
            chk("b2b_fd", 32'(fd1), 32'((i == 9) || (i == 19)));
            chk("b2b_busy", 32'(busy1), 32'(i != 20));
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset during the 4th data symbol of an A5 frame
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_abort_busy", 32'(busy1), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_sym1", 32'(sym1), 32'h1);
        chk("abort_busy1", 32'(busy1), 32'd0);
        chk("abort_sym0", 32'(sym0), 32'h1);
        chk("abort_fd1", 32'(fd1), 32'd0);
        @(negedge clk);
        rstn    = 1'b1;
        fd_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (fd1 || fd0) fd_seen++;
        end
        chk("abort_no_done", 32'(fd_seen), 32'd0);
        chk("abort_idle_rdy", 32'(rdy1), 32'd1);
        run_frame(vecs[1].pen, vecs[1].data, vecs[1].syms, vecs[1].len);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
